an_decode_argmax_seq: RTL



---
 rtl/an_pkg.sv | 30 +++
 rtl/an_seq_divider.sv | 50 +++++
 rtl/an_decode_argmax_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/an_pkg.sv
// Shared definitions for the sequential AN-code decode / argmax stage.
package an_pkg;

    localparam int CW_W_DEF  = 29;
    localparam int MSG_W_DEF = 24;
    localparam int A_DEF     = 59;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_EVAL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_DIV  = ST_DIV,
        S_EVAL = ST_EVAL,
        S_DONE = ST_DONE
    } an_state_t;

    // Magnitude of a sign-extended two's complement value.
    function automatic logic [63:0] an_abs(input logic [63:0] v);
        return v[63] ? (64'd0 - v) : v;
    endfunction

    // Re-applies a captured sign to an unsigned magnitude.
    function automatic logic [63:0] an_u2s(input logic [63:0] mag, input logic neg);
        return neg ? (64'd0 - mag) : mag;
    endfunction

endpackage

// File: rtl/an_seq_divider.sv
// Restoring unsigned divider by a constant, one quotient bit per cycle.
// o_done is high during the final step; quotient/remainder are valid the
// following cycle and hold until the next start.
module an_seq_divider #(
    parameter int CW_W = 29,
    parameter int A    = 59
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [CW_W-1:0] i_dividend,
    output logic [CW_W-1:0] o_quotient,
    output logic [CW_W-1:0] o_remainder,
    output logic            o_done
);
    localparam int CNT_W = $clog2(CW_W + 1);
    localparam int DW    = CW_W + 1;
    localparam logic [DW-1:0] DIVISOR = DW'(A);

    logic [CW_W-1:0]  r_quo;
    logic [CW_W-1:0]  r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    w_trial;
    logic             w_fit;

    assign w_trial = {r_rem, r_quo[CW_W-1]};
    assign w_fit   = (w_trial >= DIVISOR);

    // Load on start, then shift/subtract one bit per cycle until the count expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_cnt <= CNT_W'(CW_W);
        end else if (r_cnt != '0) begin
            r_rem <= w_fit ? CW_W'(w_trial - DIVISOR) : w_trial[CW_W-1:0];
            r_quo <= {r_quo[CW_W-2:0], w_fit};
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_done      = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/an_decode_argmax_seq.sv
// Time-shared AN-code check/decode of N_CH codewords with argmax over the
// decoded messages and a per-channel residue error report.
//
//   state | meaning
//   IDLE  | waiting for valid; samples layer_in
//   DIV   | divider running on |cw[ch]|
//   EVAL  | residue check, signed decode, argmax update for ch
//   DONE  | ready pulse; results held on outputs
module an_decode_argmax_seq
    import an_pkg::*;
#(
    parameter int N_CH     = 10,
    parameter int CW_W     = CW_W_DEF,
    parameter int MSG_W    = MSG_W_DEF,
    parameter int A        = A_DEF,
    parameter int MASK_ERR = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid,
    input  logic [N_CH*CW_W-1:0]      layer_in,
    output logic                      busy,
    output logic                      ready,
    output logic [31:0]               predict,
    output logic [N_CH-1:0]           err_mask,
    output logic [$clog2(N_CH+1)-1:0] err_count
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ECW   = $clog2(N_CH + 1);

    an_state_t                r_state;
    logic [N_CH*CW_W-1:0]     r_layer;
    logic [IDX_W-1:0]         r_ch;
    logic                     r_neg;
    logic                     r_best_vld;
    logic signed [MSG_W-1:0]  r_best_q;
    logic [IDX_W-1:0]         r_best_idx;
    logic [N_CH-1:0]          r_mask_acc;
    logic [ECW-1:0]           r_cnt_acc;
    logic                     r_busy;
    logic                     r_ready;
    logic [31:0]              r_predict;
    logic [N_CH-1:0]          r_err_mask;
    logic [ECW-1:0]           r_err_count;

    logic                     w_last_ch;
    logic [IDX_W-1:0]         w_next_ch;
    logic [CW_W-1:0]          w_src_cw;
    logic                     w_src_neg;
    logic [CW_W-1:0]          w_dividend;
    logic                     w_start;
    logic [CW_W-1:0]          w_quo;
    logic [CW_W-1:0]          w_rem;
    logic                     w_div_done;
    logic                     w_err;
    logic signed [MSG_W-1:0]  w_q;
    logic                     w_take;

    assign w_last_ch = (r_ch == IDX_W'(N_CH - 1));
    assign w_next_ch = w_last_ch ? '0 : r_ch + 1'b1;

    // From IDLE the divider is loaded straight from the input bus, since the
    // layer register is written on the same edge.
    assign w_src_cw   = (r_state == S_IDLE) ? layer_in[CW_W-1:0]
                                            : r_layer[CW_W*w_next_ch +: CW_W];
    assign w_src_neg  = w_src_cw[CW_W-1];
    assign w_dividend = CW_W'(an_abs(64'(signed'(w_src_cw))));
    assign w_start    = ((r_state == S_IDLE) && valid) ||
                        ((r_state == S_EVAL) && !w_last_ch);

    an_seq_divider #(
        .CW_W (CW_W),
        .A    (A)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_dividend  (w_dividend),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_done      (w_div_done)
    );

    assign w_err  = (w_rem != '0);
    assign w_q    = MSG_W'(an_u2s(64'(w_quo), r_neg));
    assign w_take = !(w_err && (MASK_ERR != 0)) && (!r_best_vld || (w_q > r_best_q));

    // Sequencing FSM with argmax tracking and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_layer     <= '0;
            r_ch        <= '0;
            r_neg       <= 1'b0;
            r_best_vld  <= 1'b0;
            r_best_q    <= '0;
            r_best_idx  <= '0;
            r_mask_acc  <= '0;
            r_cnt_acc   <= '0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_predict   <= '0;
            r_err_mask  <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_layer    <= layer_in;
                        r_ch       <= '0;
                        r_neg      <= w_src_neg;
                        r_best_vld <= 1'b0;
                        r_mask_acc <= '0;
                        r_cnt_acc  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (w_div_done) r_state <= S_EVAL;
                end
                S_EVAL: begin
                    r_mask_acc[r_ch] <= w_err;
                    r_cnt_acc        <= r_cnt_acc + ECW'(w_err);
                    if (w_take) begin
                        r_best_vld <= 1'b1;
                        r_best_q   <= w_q;
                        r_best_idx <= r_ch;
                    end
                    if (w_last_ch) begin
                        r_ready     <= 1'b1;
                        r_predict   <= w_take     ? 32'(r_ch) :
                                       r_best_vld ? 32'(r_best_idx) : 32'hFFFF_FFFF;
                        r_err_mask  <= r_mask_acc | (N_CH'(w_err) << r_ch);
                        r_err_count <= r_cnt_acc + ECW'(w_err);
                        r_state     <= S_DONE;
                    end else begin
                        r_ch    <= w_next_ch;
                        r_neg   <= w_src_neg;
                        r_state <= S_DIV;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign ready     = r_ready;
    assign predict   = r_predict;
    assign err_mask  = r_err_mask;
    assign err_count = r_err_count;

endmodule
